// File: rtl/vid_pkg.sv
// Shared types and beat-field helpers for the video stream checker.
// Symbol 0 of each beat arrives first in data[7:0].
package vid_pkg;

  localparam int PIXEL_W = 24;
  localparam int SYM_W   = 8;

  typedef enum logic [3:0] {
    PKT_VIDEO = 4'h0,
    PKT_CTRL  = 4'hF
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_VIDEO,
    ST_DRAIN
  } rx_state_e;

  // Low nibble of each of the three symbols, symbol 0 in the top bits.
  function automatic logic [11:0] beat_nibbles(
    input logic [PIXEL_W-1:0] d
  );
    return {d[3:0], d[SYM_W+3:SYM_W], d[2*SYM_W+3:2*SYM_W]};
  endfunction

endpackage

// File: rtl/video_stream_checker_if.sv
// Avalon-ST video link: 24-bit beats with packet framing
// and a ready signal that has a one-cycle latency.
interface video_stream_checker_if;
  import vid_pkg::*;

  logic [PIXEL_W-1:0] data;
  logic               valid;
  logic               startofpacket;
  logic               endofpacket;
  logic               ready;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );

endinterface

// File: rtl/vid_ctrl_decoder.sv
// Assembles control packet payload nibbles into shadow
// width/height/interlace registers, committed at EOP.
module vid_ctrl_decoder
  import vid_pkg::*;
#(
  parameter int DIM_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             beat,
  input  logic             last,
  input  logic [11:0]      nib,
  output logic [DIM_W-1:0] width,
  output logic [DIM_W-1:0] height,
  output logic [3:0]       interlace,
  output logic             seen,
  output logic             err
);

  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] tw_q, tw_d;
  logic [15:0] th_q, th_d;
  logic [3:0]  til_q, til_d;
  logic        commit;

  always_comb begin
    cnt_d = cnt_q;
    tw_d  = tw_q;
    th_d  = th_q;
    til_d = til_q;
    if (start) begin
      cnt_d = 2'd0;
    end else if (beat && cnt_q != 2'd3) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0: tw_d[15:4] = nib;
        2'd1: begin
          tw_d[3:0]  = nib[11:8];
          th_d[15:8] = nib[7:0];
        end
        default: begin
          th_d[7:0] = nib[11:4];
          til_d     = nib[3:0];
        end
      endcase
    end
    commit = last && cnt_d == 2'd3
          && tw_d != 16'd0 && th_d != 16'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      tw_q      <= '0;
      th_q      <= '0;
      til_q     <= '0;
      width     <= '0;
      height    <= '0;
      interlace <= '0;
      seen      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tw_q  <= tw_d;
      th_q  <= th_d;
      til_q <= til_d;
      err   <= last && !commit;
      if (commit) begin
        width     <= DIM_W'(tw_d);
        height    <= DIM_W'(th_d);
        interlace <= til_d;
        seen      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_stream_checker.sv
// Avalon-ST video sink: checks frame sizes against the
// last control packet and reports status and checksums.
module video_stream_checker
  import vid_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  video_stream_checker_if.slave asi_in0,
  input  logic                 hold,
  output logic [DIM_W-1:0]     frame_width,
  output logic [DIM_W-1:0]     frame_height,
  output logic [3:0]           frame_interlace,
  output logic                 ctrl_seen,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_ctrl,
  output logic                 err_no_ctrl,
  output logic                 err_proto,
  output logic [CNT_W-1:0]     frame_count,
  output logic [31:0]          pixel_sum
);

  rx_state_e        state_q, state_d;
  logic             ready_q;
  logic             acc, stall, sop, eop;
  logic             is_vid, is_ctrl, vid_sop, abort;
  logic             pix, last_pix, over;
  logic             done_d, ok_d, short_d, long_d;
  logic             noctrl_d, proto_d;
  logic [31:0]      sum_q, sum_d, psum_d;
  logic [DIM_W-1:0] fw_q, fh_q, col_q, row_q;
  logic             cmp_q, long_q, perr_q;

  assign asi_in0.ready = ready_q;
  assign acc     = asi_in0.valid && ready_q;
  assign stall   = asi_in0.valid && !ready_q;
  assign sop     = acc && asi_in0.startofpacket;
  assign eop     = acc && asi_in0.endofpacket;
  assign is_vid  = asi_in0.data[3:0] == PKT_VIDEO;
  assign is_ctrl = asi_in0.data[3:0] == PKT_CTRL;
  assign vid_sop = sop && is_vid;
  assign abort   = sop && state_q == ST_VIDEO;

  vid_ctrl_decoder #(.DIM_W(DIM_W)) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .start     (sop && is_ctrl),
    .beat      (acc && !sop && state_q == ST_CTRL),
    .last      (eop && (sop ? is_ctrl : state_q == ST_CTRL)),
    .nib       (beat_nibbles(asi_in0.data)),
    .width     (frame_width),
    .height    (frame_height),
    .interlace (frame_interlace),
    .seen      (ctrl_seen),
    .err       (err_ctrl)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      sop && eop:
        state_d = ST_IDLE;
      sop && !eop && is_ctrl:
        state_d = ST_CTRL;
      sop && !eop && is_vid && ctrl_seen:
        state_d = ST_VIDEO;
      sop && !eop && !is_ctrl && !(is_vid && ctrl_seen):
        state_d = ST_DRAIN;
      !sop && eop:
        state_d = ST_IDLE;
      default:
        state_d = state_q;
    endcase
  end

  always_comb begin
    pix      = acc && !sop && state_q == ST_VIDEO;
    last_pix = pix && !cmp_q
            && row_q == fh_q - DIM_W'(1)
            && col_q == fw_q - DIM_W'(1);
    over     = pix && cmp_q;
    sum_d    = sum_q + ((pix && !cmp_q) ? 32'(asi_in0.data) : 32'd0);
    done_d   = 1'b0;
    ok_d     = 1'b0;
    short_d  = 1'b0;
    long_d   = over && !long_q;
    noctrl_d = vid_sop && !ctrl_seen;
    proto_d  = stall || (sop && state_q != ST_IDLE);
    psum_d   = sum_q;
    if (abort) done_d = 1'b1;
    if (pix && eop) begin
      done_d  = 1'b1;
      short_d = !(cmp_q || last_pix);
      ok_d    = (cmp_q || last_pix) && !long_q && !over && !perr_q;
      psum_d  = sum_d;
    end
    // A one-beat video packet is a frame with no pixels at all.
    if (vid_sop && ctrl_seen && eop) begin
      done_d  = 1'b1;
      short_d = 1'b1;
      psum_d  = 32'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      fw_q    <= '0;
      fh_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cmp_q   <= 1'b0;
      long_q  <= 1'b0;
      perr_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      ready_q <= !hold;
      if (vid_sop && ctrl_seen) begin
        fw_q   <= frame_width;
        fh_q   <= frame_height;
        col_q  <= '0;
        row_q  <= '0;
        cmp_q  <= 1'b0;
        long_q <= 1'b0;
        perr_q <= 1'b0;
        sum_q  <= '0;
      end else if (pix) begin
        sum_q <= sum_d;
        if (over) long_q <= 1'b1;
        if (last_pix) cmp_q <= 1'b1;
        if (!cmp_q) begin
          if (col_q == fw_q - DIM_W'(1)) begin
            col_q <= '0;
            row_q <= row_q + DIM_W'(1);
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
      end
      if (state_q == ST_VIDEO && stall) perr_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_no_ctrl <= 1'b0;
      err_proto   <= 1'b0;
      frame_count <= '0;
      pixel_sum   <= '0;
    end else begin
      frame_done  <= done_d;
      frame_ok    <= ok_d;
      err_short   <= short_d;
      err_long    <= long_d;
      err_no_ctrl <= noctrl_d;
      err_proto   <= proto_d;
      if (ok_d) frame_count <= frame_count + CNT_W'(1);
      if (done_d) pixel_sum <= psum_d;
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Directed bench for video_stream_checker: control decode,
// frame size checks, protocol errors and reset behaviour.
module tb_video_stream_checker;
  import vid_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [15:0] frame_width, frame_height;
  logic [3:0]  frame_interlace;
  logic        ctrl_seen, frame_done, frame_ok;
  logic        err_short, err_long, err_ctrl;
  logic        err_no_ctrl, err_proto;
  logic [15:0] frame_count;
  logic [31:0] pixel_sum;

  video_stream_checker_if bus();

  video_stream_checker #(.DIM_W(16), .CNT_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .asi_in0         (bus),
    .hold            (hold),
    .frame_width     (frame_width),
    .frame_height    (frame_height),
    .frame_interlace (frame_interlace),
    .ctrl_seen       (ctrl_seen),
    .frame_done      (frame_done),
    .frame_ok        (frame_ok),
    .err_short       (err_short),
    .err_long        (err_long),
    .err_ctrl        (err_ctrl),
    .err_no_ctrl     (err_no_ctrl),
    .err_proto       (err_proto),
    .frame_count     (frame_count),
    .pixel_sum       (pixel_sum)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit rnd_hold = 1'b0;

  int n_done = 0, n_ok = 0, n_short = 0, n_long = 0;
  int n_ctrl = 0, n_noctrl = 0, n_proto = 0;
  int b_done, b_ok, b_short, b_long, b_ctrl, b_noctrl, b_proto;

  always @(negedge clock) begin
    if (frame_done)  n_done++;
    if (frame_ok)    n_ok++;
    if (err_short)   n_short++;
    if (err_long)    n_long++;
    if (err_ctrl)    n_ctrl++;
    if (err_no_ctrl) n_noctrl++;
    if (err_proto)   n_proto++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_done = n_done; b_ok = n_ok; b_short = n_short;
    b_long = n_long; b_ctrl = n_ctrl; b_noctrl = n_noctrl;
    b_proto = n_proto;
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic beat(input logic [23:0] d, input logic s,
                      input logic e);
    int n;
    n = 0;
    @(negedge clock);
    hold = rnd_hold ? ($urandom_range(0, 9) < 3) : 1'b0;
    while (!bus.ready) begin
      n++;
      if (n > 50) begin
        chk("ready_timeout", 32'(bus.ready), 32'd1);
        return;
      end
      @(negedge clock);
      hold = rnd_hold ? ($urandom_range(0, 9) < 3) : 1'b0;
    end
    bus.data = d;
    bus.valid = 1'b1;
    bus.startofpacket = s;
    bus.endofpacket = e;
    @(posedge clock);
    #1;
    bus.valid = 1'b0;
    bus.startofpacket = 1'b0;
    bus.endofpacket = 1'b0;
  endtask

  task automatic video(input int n, input logic [23:0] v,
                       input bit inc);
    beat(24'h0, 1'b1, n == 0);
    for (int i = 0; i < n; i++)
      beat(inc ? 24'(i + 1) : v, 1'b0, i == n - 1);
  endtask

  initial begin
    bus.data = '0;
    bus.valid = 1'b0;
    bus.startofpacket = 1'b0;
    bus.endofpacket = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_seen", 32'(ctrl_seen), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_sum", pixel_sum, 32'd0);
    reset = 1'b0;

    snap();
    video(3, 24'h123456, 1'b0);
    settle();
    chk("noctrl_pulse", n_noctrl - b_noctrl, 1);
    chk("noctrl_done", n_done - b_done, 0);
    chk("noctrl_seen", 32'(ctrl_seen), 32'd0);

    beat(24'h00000F, 1'b1, 1'b0);
    beat(24'h000000, 1'b0, 1'b0);
    beat(24'h000004, 1'b0, 1'b0);
    beat(24'h020200, 1'b0, 1'b1);
    settle();
    chk("ctrl_w", 32'(frame_width), 32'd4);
    chk("ctrl_h", 32'(frame_height), 32'd2);
    chk("ctrl_il", 32'(frame_interlace), 32'd2);
    chk("ctrl_seen", 32'(ctrl_seen), 32'd1);

    snap();
    video(8, 24'hFFFFFF, 1'b0);
    @(negedge clock);
    chk("ok_done", 32'(frame_done), 32'd1);
    chk("ok_ok", 32'(frame_ok), 32'd1);
    settle();
    chk("ok_count", 32'(frame_count), 32'd1);
    chk("ok_sum", pixel_sum, 32'h07FFFFF8);
    chk("ok_short", n_short - b_short, 0);
    chk("ok_long", n_long - b_long, 0);

    snap();
    video(7, 24'h0, 1'b1);
    settle();
    chk("short_done", n_done - b_done, 1);
    chk("short_err", n_short - b_short, 1);
    chk("short_ok", n_ok - b_ok, 0);
    chk("short_count", 32'(frame_count), 32'd1);
    chk("short_sum", pixel_sum, 32'h1C);

    snap();
    video(10, 24'h0, 1'b1);
    settle();
    chk("long_err", n_long - b_long, 1);
    chk("long_short", n_short - b_short, 0);
    chk("long_ok", n_ok - b_ok, 0);
    chk("long_sum", pixel_sum, 32'h24);

    rnd_hold = 1'b1;
    beat(24'h00000F, 1'b1, 1'b0);
    beat(24'h000100, 1'b0, 1'b0);
    beat(24'h00000E, 1'b0, 1'b0);
    beat(24'h00080C, 1'b0, 1'b1);
    settle();
    chk("big_w", 32'(frame_width), 32'd270);
    chk("big_h", 32'(frame_height), 32'd200);
    chk("big_il", 32'(frame_interlace), 32'd0);
    beat(24'h00000F, 1'b1, 1'b0);
    beat(24'h000100, 1'b0, 1'b0);
    beat(24'h00000E, 1'b0, 1'b0);
    beat(24'h000200, 1'b0, 1'b1);
    snap();
    video(540, 24'h000001, 1'b0);
    settle();
    rnd_hold = 1'b0;
    chk("hold_ok", n_ok - b_ok, 1);
    chk("hold_count", 32'(frame_count), 32'd2);
    chk("hold_sum", pixel_sum, 32'h21C);
    chk("hold_proto", n_proto - b_proto, 0);

    snap();
    @(negedge clock);
    hold = 1'b1;
    @(negedge clock);
    bus.data = 24'h0;
    bus.valid = 1'b1;
    @(posedge clock);
    #1;
    bus.valid = 1'b0;
    hold = 1'b0;
    settle();
    chk("stall_proto", n_proto - b_proto, 1);
    chk("stall_ready", 32'(bus.ready), 32'd1);

    snap();
    beat(24'h000000, 1'b1, 1'b0);
    beat(24'h000011, 1'b0, 1'b0);
    beat(24'h000022, 1'b0, 1'b0);
    beat(24'h000005, 1'b1, 1'b0);
    beat(24'h000000, 1'b0, 1'b1);
    settle();
    chk("abort_proto", n_proto - b_proto, 1);
    chk("abort_done", n_done - b_done, 1);
    chk("abort_ok", n_ok - b_ok, 0);
    chk("abort_short", n_short - b_short, 0);

    snap();
    beat(24'h00000F, 1'b1, 1'b0);
    beat(24'h000000, 1'b0, 1'b0);
    beat(24'h000004, 1'b0, 1'b1);
    beat(24'h00000F, 1'b1, 1'b0);
    beat(24'h000000, 1'b0, 1'b0);
    beat(24'h000000, 1'b0, 1'b0);
    beat(24'h020200, 1'b0, 1'b1);
    settle();
    chk("badctrl_err", n_ctrl - b_ctrl, 2);
    chk("badctrl_w", 32'(frame_width), 32'd270);
    chk("badctrl_h", 32'(frame_height), 32'd2);

    beat(24'h000000, 1'b1, 1'b0);
    beat(24'h000001, 1'b0, 1'b0);
    beat(24'h000001, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    chk("mid_rst_seen", 32'(ctrl_seen), 32'd0);
    chk("mid_rst_count", 32'(frame_count), 32'd0);
    chk("mid_rst_w", 32'(frame_width), 32'd0);
    chk("mid_rst_sum", pixel_sum, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    snap();
    video(8, 24'hFFFFFF, 1'b0);
    settle();
    chk("post_rst_noctrl", n_noctrl - b_noctrl, 1);
    chk("post_rst_done", n_done - b_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
